// File: rtl/eint_ctrl_prio.sv
// Prioritised external interrupt controller with claim/complete; `EINT_PREEMPT_EN enables nested preemption.
// Latency: edge source to mextern_int 4 cycles; register write to output 2 cycles; rdata 1 cycle after sel_read.
// Backpressure: none, single-cycle bus strobes are always accepted.
module eint_ctrl_prio #(
  parameter int INT_NUM    = 13,
  parameter int PRIO_BITS  = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  hb_clk,
  input  logic                  rst_n,
  input  logic                  sel_read,
  input  logic                  sel_write,
  input  logic [ADDR_WIDTH-1:0] sel_addr,
  input  logic [31:0]           sel_wdata,
  output logic [31:0]           rdata,
  input  logic [INT_NUM-1:0]    irq_source,
  output logic                  mextern_int,
  output logic [30:0]           mextern_int_id
);

  localparam int ID_W   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;
  localparam int WORD_W = ADDR_WIDTH - 2;

  localparam logic [WORD_W-1:0] W_ENABLE = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_MODE   = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_PEND   = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_THR    = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_CLAIM  = WORD_W'(4);
  localparam logic [WORD_W-1:0] W_PRIO0  = WORD_W'(8);

  logic [WORD_W-1:0]    widx;
  logic                 unused_addr_bits;
  logic [INT_NUM-1:0]   enable_q, mode_q, pend_q, in_svc_q;
  logic [PRIO_BITS-1:0] thr_q;
  logic [PRIO_BITS-1:0] prio_q [INT_NUM];
  logic [INT_NUM-1:0]   sync1, sync2, sync3, edge_det;
  logic [PRIO_BITS-1:0] eff_thr, win_prio;
  logic                 win_vld, req_vld, claim_go;
  logic [ID_W-1:0]      win_id;
  logic [INT_NUM-1:0]   clm_mask, cmp_mask, w1c_mask;
  logic [31:0]          rd_val;

  assign widx             = sel_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^sel_addr[1:0];
  assign edge_det         = sync2 & ~sync3;

  always_comb begin
    eff_thr = thr_q;
`ifdef EINT_PREEMPT_EN
    // Nested claims: only strictly higher priority than anything in service may interrupt.
    for (int i = 0; i < INT_NUM; i++)
      if (in_svc_q[i] && prio_q[i] > eff_thr) eff_thr = prio_q[i];
`endif
  end

  // Ascending scan with strict compare keeps the lowest ID on priority ties.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (pend_q[i] && enable_q[i] && !in_svc_q[i] &&
          prio_q[i] > eff_thr && prio_q[i] > win_prio) begin
        win_vld  = 1'b1;
        win_id   = ID_W'(i);
        win_prio = prio_q[i];
      end
    end
  end

`ifdef EINT_PREEMPT_EN
  assign req_vld = win_vld;
`else
  assign req_vld = win_vld && (in_svc_q == '0);
`endif

  assign claim_go = sel_read && (widx == W_CLAIM) && req_vld;
  assign w1c_mask = (sel_write && widx == W_PEND) ? (sel_wdata[INT_NUM-1:0] & mode_q) : '0;

  always_comb begin
    clm_mask = '0;
    cmp_mask = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      clm_mask[i] = claim_go && (win_id == ID_W'(i));
      cmp_mask[i] = sel_write && (widx == W_CLAIM) && (sel_wdata == 32'(i));
    end
  end

  always_comb begin
    rd_val = '0;
    case (widx)
      W_ENABLE: rd_val = 32'(enable_q);
      W_MODE:   rd_val = 32'(mode_q);
      W_PEND:   rd_val = 32'(pend_q);
      W_THR:    rd_val = 32'(thr_q);
      W_CLAIM:  rd_val = req_vld ? (32'h8000_0000 | 32'(win_id)) : 32'h0;
      default: begin
        for (int i = 0; i < INT_NUM; i++)
          if (widx == W_PRIO0 + WORD_W'(i)) rd_val = 32'(prio_q[i]);
      end
    endcase
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1          <= '0;
      sync2          <= '0;
      sync3          <= '0;
      enable_q       <= '0;
      mode_q         <= '0;
      pend_q         <= '0;
      in_svc_q       <= '0;
      thr_q          <= '0;
      for (int i = 0; i < INT_NUM; i++) prio_q[i] <= '0;
      rdata          <= '0;
      mextern_int    <= 1'b0;
      mextern_int_id <= '0;
    end else begin
      sync1 <= irq_source;
      sync2 <= sync1;
      sync3 <= sync2;
      // A fresh edge overrides a same-cycle clear; level sources just track the line.
      pend_q   <= (mode_q & ((pend_q & ~(w1c_mask | clm_mask)) | edge_det)) | (~mode_q & sync2);
      in_svc_q <= (in_svc_q & ~cmp_mask) | clm_mask;
      if (sel_write) begin
        case (widx)
          W_ENABLE: enable_q <= sel_wdata[INT_NUM-1:0];
          W_MODE:   mode_q   <= sel_wdata[INT_NUM-1:0];
          W_THR:    thr_q    <= sel_wdata[PRIO_BITS-1:0];
          default: ;
        endcase
        for (int i = 0; i < INT_NUM; i++)
          if (widx == W_PRIO0 + WORD_W'(i)) prio_q[i] <= sel_wdata[PRIO_BITS-1:0];
      end
      if (sel_read) rdata <= rd_val;
      mextern_int    <= req_vld;
      mextern_int_id <= req_vld ? 31'(win_id) : '0;
    end
  end

endmodule

// File: tb/tb_eint_ctrl_prio.sv
// Randomised and directed bench for eint_ctrl_prio against a cycle-level behavioural model.
module tb_eint_ctrl_prio;
  localparam int INT_NUM   = 13;
  localparam int PRIO_BITS = 3;

  logic               hb_clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               sel_read = 1'b0;
  logic               sel_write = 1'b0;
  logic [7:0]         sel_addr = '0;
  logic [31:0]        sel_wdata = '0;
  logic [31:0]        rdata;
  logic [INT_NUM-1:0] irq_source = '0;
  logic               mextern_int;
  logic [30:0]        mextern_int_id;

  eint_ctrl_prio #(.INT_NUM(INT_NUM), .PRIO_BITS(PRIO_BITS), .ADDR_WIDTH(8)) dut (
    .hb_clk(hb_clk), .rst_n(rst_n), .sel_read(sel_read), .sel_write(sel_write),
    .sel_addr(sel_addr), .sel_wdata(sel_wdata), .rdata(rdata), .irq_source(irq_source),
    .mextern_int(mextern_int), .mextern_int_id(mextern_int_id)
  );

  always #5 hb_clk = ~hb_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: register file, pending/in-service sets and a delay line for the raw lines.
  logic [INT_NUM-1:0] m_en, m_mode, m_pend, m_insvc, m_d1, m_d2, m_d3;
  int                 m_thr;
  int                 m_prio [INT_NUM];
  logic               m_int;
  int                 m_id;
  logic [31:0]        m_rdata;

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_pend = '0; m_insvc = '0;
    m_d1 = '0; m_d2 = '0; m_d3 = '0;
    m_thr = 0; m_int = 1'b0; m_id = 0; m_rdata = '0;
    for (int i = 0; i < INT_NUM; i++) m_prio[i] = 0;
  endtask

  function automatic int winner();
    int t = m_thr;
    int best = -1;
    int bp = 0;
`ifdef EINT_PREEMPT_EN
    for (int i = 0; i < INT_NUM; i++)
      if (m_insvc[i] && m_prio[i] > t) t = m_prio[i];
`endif
    for (int i = 0; i < INT_NUM; i++)
      if (m_pend[i] && m_en[i] && !m_insvc[i] && m_prio[i] > t && m_prio[i] > bp) begin
        best = i;
        bp = m_prio[i];
      end
`ifndef EINT_PREEMPT_EN
    if (m_insvc != '0) best = -1;
`endif
    return best;
  endfunction

  function automatic logic [31:0] reg_val(input int a);
    case (a)
      0:  return 32'(m_en);
      4:  return 32'(m_mode);
      8:  return 32'(m_pend);
      12: return 32'(m_thr);
      default: if (a >= 32 && a < 32 + 4 * INT_NUM) return 32'(m_prio[(a - 32) / 4]);
    endcase
    return 32'h0;
  endfunction

  task automatic model_step();
    int w = winner();
    int wa = int'(sel_addr & 8'hFC);
    logic [INT_NUM-1:0] mode_old = m_mode;
    logic [INT_NUM-1:0] edges = m_d2 & ~m_d3;
    logic [INT_NUM-1:0] clr = '0;
    logic [31:0] cid = sel_wdata;
    if (sel_read) begin
      if (wa == 16) begin
        if (w >= 0) begin
          m_rdata = 32'h8000_0000 | 32'(w);
          m_insvc[w] = 1'b1;
          clr[w] = 1'b1;
        end else m_rdata = 32'h0;
      end else m_rdata = reg_val(wa);
    end
    if (sel_write) begin
      case (wa)
        0:  m_en = sel_wdata[INT_NUM-1:0];
        4:  m_mode = sel_wdata[INT_NUM-1:0];
        8:  clr = clr | sel_wdata[INT_NUM-1:0];
        12: m_thr = int'(sel_wdata[PRIO_BITS-1:0]);
        16: if (cid < INT_NUM) m_insvc[cid[4:0]] = 1'b0;
        default: if (wa >= 32 && wa < 32 + 4 * INT_NUM)
          m_prio[(wa - 32) / 4] = int'(sel_wdata[PRIO_BITS-1:0]);
      endcase
    end
    for (int i = 0; i < INT_NUM; i++)
      m_pend[i] = mode_old[i] ? ((m_pend[i] && !clr[i]) || edges[i]) : m_d2[i];
    m_int = (w >= 0);
    m_id  = (w >= 0) ? w : 0;
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = irq_source;
  endtask

  task automatic cycle();
    @(posedge hb_clk);
    model_step();
    @(negedge hb_clk);
    check("int", 32'(mextern_int), 32'(m_int));
    check("id", 32'(mextern_int_id), 32'(m_id));
    check("rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    sel_addr = 8'(a); sel_wdata = d; sel_write = 1'b1;
    cycle();
    sel_write = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    sel_addr = 8'(a); sel_read = 1'b1;
    cycle();
    sel_read = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input int src);
    irq_source[src] = 1'b1;
    cycle();
    irq_source[src] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_int", 32'(mextern_int), 32'h0);
    check("rst_id", 32'(mextern_int_id), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge hb_clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] d;
  int          addrs [7] = '{0, 4, 8, 12, 16, 32, 32 + 4 * (INT_NUM - 1)};

  initial begin
    #2;
    apply_reset();
    foreach (addrs[k]) begin
      rd(addrs[k], d);
      check("rst_reg", d, 32'h0);
    end

    // Single edge source end to end.
    wr(32 + 4 * 3, 2); wr(0, 32'h8); wr(4, 32'h8); wr(12, 0);
    pulse(3); idle(3);
    check("edge_int", 32'(mextern_int), 32'h1);
    check("edge_id", 32'(mextern_int_id), 32'h3);
    rd(16, d);
    check("claim3", d, 32'h8000_0003);
    cycle();
    check("claim_drop", 32'(mextern_int), 32'h0);
    wr(16, 3);
    rd(16, d);
    check("claim_empty", d, 32'h0);

    // Level sources, priority and tie-break.
    wr(4, 0); wr(32 + 4 * 1, 4); wr(32 + 4 * 5, 4); wr(32 + 4 * 2, 6); wr(0, 32'h26);
    irq_source = 13'h26; idle(5);
    check("prio_id", 32'(mextern_int_id), 32'h2);
    wr(0, 32'h22); idle(2);
    check("tie_id", 32'(mextern_int_id), 32'h1);

    // Threshold boundary.
    wr(0, 32'h20); wr(12, 4); idle(3);
    check("thr_block", 32'(mextern_int), 32'h0);
    wr(12, 3); idle(3);
    check("thr_pass", 32'(mextern_int), 32'h1);
    check("thr_id", 32'(mextern_int_id), 32'h5);

    // Edge and W1C in the same cycle: the set must win.
    irq_source = '0; wr(12, 0); wr(0, 0); wr(4, 1); idle(4);
    irq_source[0] = 1'b1; cycle(); cycle();
    wr(8, 1);
    rd(8, d);
    check("w1c_race", d & 32'h1, 32'h1);
    wr(8, 1);
    rd(8, d);
    check("w1c_clear", d & 32'h1, 32'h0);
    irq_source[0] = 1'b0;

    // Claim low priority, then a higher priority request arrives.
    wr(4, 32'h12); wr(32 + 4 * 1, 2); wr(32 + 4 * 4, 5); wr(0, 32'h12);
    pulse(1); idle(4);
    rd(16, d);
    check("claim1", d, 32'h8000_0001);
    pulse(4); idle(5);
`ifdef EINT_PREEMPT_EN
    check("preempt_int", 32'(mextern_int), 32'h1);
    check("preempt_id", 32'(mextern_int_id), 32'h4);
`else
    check("nopreempt_int", 32'(mextern_int), 32'h0);
`endif
    wr(16, 1); idle(2);
    check("after_cmp_int", 32'(mextern_int), 32'h1);
    check("after_cmp_id", 32'(mextern_int_id), 32'h4);

    // Random traffic with a mid-run asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      int op = $urandom_range(0, 9);
      int k = $urandom_range(0, 8);
      int a;
      if (n == 1500) apply_reset();
      if ($urandom_range(0, 2) == 0) irq_source[$urandom_range(0, INT_NUM - 1)] ^= 1'b1;
      case (k)
        0: a = 0; 1: a = 4; 2: a = 8; 3: a = 12; 4: a = 16;
        5: a = 32 + 4 * $urandom_range(0, INT_NUM - 1);
        6: a = 20; 7: a = 32 + 4 * INT_NUM;
        default: a = 252;
      endcase
      if (op <= 2) wr(a, (a == 12) ? 32'($urandom_range(0, 3)) : 32'($urandom));
      else if (op <= 4) rd(a, d);
      else if (op == 5) rd(16, d);
      else if (op == 6) wr(16, 32'($urandom_range(0, 15)));
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/eint_ctrl_prio.md
# eint_ctrl_prio

Prioritised external interrupt controller for the XT_HB high-speed bus; parametrised successor of the flat external interrupt controller. Collects up to 31 asynchronous interrupt sources and applies per-source enable, edge/level mode and priority plus a global threshold. Presents the winning request to the core as `mextern_int`/`mextern_int_id`, with a claim/complete handshake. Occupies one XT_HB slave slot.

## Interface
Parameters:
- `INT_NUM`, 13, number of sources (1..31)
- `PRIO_BITS`, 3, priority field width (1..8); priority 0 = never interrupts
- `ADDR_WIDTH`, 8, byte-offset width of the register window

Ports:
- `hb_clk`  in  1  bus/system clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `sel_read`  in  1  bus read strobe, single cycle
- `sel_write`  in  1  bus write strobe, single cycle
- `sel_addr`  in  ADDR_WIDTH  byte offset, word aligned; bits [1:0] ignored
- `sel_wdata`  in  32  write data
- `rdata`  out  32  read data
- `irq_source`  in  INT_NUM  raw interrupt lines, any clock domain
- `mextern_int`  out  1  machine external interrupt request
- `mextern_int_id`  out  31  ID of the winning source

## Operation
- Each `irq_source[i]` passes a 2-flop synchroniser, then a rising-edge detector.
- Registers (offsets):
  - 0x00 ENABLE, RW, INT_NUM bits
  - 0x04 MODE, RW; 1 = rising edge, 0 = level
  - 0x08 PENDING, RO for level sources; write-1-to-clear for edge sources
  - 0x0C THRESHOLD, RW, PRIO_BITS
  - 0x10 CLAIM on read, COMPLETE on write
  - 0x20+4*i PRIORITY[i], RW, PRIO_BITS
  - Unmapped reads return 0; unmapped writes are ignored.
- Pending bit:
  - edge: set on a detected edge, cleared by W1C or by claim
  - level: equals the synchronised level
- Eligible = pending & enabled & !in_service & PRIORITY > effective threshold.
- Arbitration: highest priority wins; ties go to the lowest ID.
- CLAIM read:
  - With a winner: returns `0x8000_0000 | id`, sets `in_service[id]` and clears an edge pending bit.
  - With no winner: returns 0 and has no side effects.
- COMPLETE write of id: clears `in_service[id]`.
  - Ignored if id >= INT_NUM or the source is not in service.
- Sources that are not in service are never affected by a claim or complete.

## Timing
- Reset values:
  - all registers, pending, in_service and synchronisers = 0
  - `rdata` = 0, `mextern_int` = 0, `mextern_int_id` = 0
- `rdata` is registered: valid one cycle after `sel_read`. It holds until the next read.
- Edge source to `mextern_int` latency is 4 cycles: synchroniser 2, pending 1, output register 1.
- `mextern_int` and `mextern_int_id` are registered from the arbitration result.
- Claim read in cycle N:
  - pending/in_service update at the end of N
  - `mextern_int` reflects the new state at N+2
- A register write in cycle N affects arbitration from N+1. It shows on the output at N+2.
- Simultaneous events:
  - a new edge and a claim/W1C of the same source in one cycle: pending stays set (set wins)
  - a COMPLETE and a new edge on the same source: both take effect
- A level source deasserting before claim: pending drops and the request is withdrawn without a claim.
- `rst_n` low mid-operation: all state returns to reset values immediately (async). Requests in flight are lost.

## Configuration
- `EINT_PREEMPT_EN`:
  - Defined: effective threshold = max(THRESHOLD, highest PRIORITY among in-service sources). Multiple nested claims are allowed, so a strictly higher priority preempts.
  - Undefined: effective threshold = THRESHOLD. While any source is in service, `mextern_int` is forced 0 and CLAIM returns 0, so only one claim is outstanding.

## Test plan
- Reset release, all sources idle:
  - every register reads 0
  - `mextern_int` = 0
- Source 3 as edge, PRIORITY[3]=2, ENABLE=0x8, THRESHOLD=0; pulse `irq_source[3]`:
  - `mextern_int` = 1 and id = 3 after 4 cycles
  - CLAIM reads 0x8000_0003 and the output drops 2 cycles later
  - COMPLETE with 3 clears in_service
- Sources 1 and 5 both level-high at priority 4; source 2 at priority 6:
  - with all three pending, id = 2
  - with 2 disabled, id = 1 (tie goes to the lower ID)
- THRESHOLD=4 with source 5 at priority 4 pending: no interrupt. THRESHOLD=3: interrupt with id = 5.
- Edge on source 0 in the same cycle as W1C of PENDING bit 0: PENDING bit 0 remains 1.
- Claim source 1 (priority 2), then raise source 4 (priority 5):
  - with `EINT_PREEMPT_EN` defined: id = 4 asserts
  - with it undefined: `mextern_int` stays 0 until COMPLETE 1, then asserts with id = 4
